// File: rtl/window_pingpong_bram.sv
// rtl/window_pingpong_bram.sv - two-bank ping-pong window buffer, writer fills one bank while reader drains the other
// Optional reject counter on o_drop_cnt enabled by WINDOW_PINGPONG_DROP_CNT_EN.
module window_pingpong_bram #(
  parameter int WIDTH  = 8,
  parameter int FILTER = 3,
  localparam int DEPTH = (2 * FILTER + 1) * (2 * FILTER + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_valid,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_wr_ready,
  output logic [AW-1:0]    o_wr_fill,
  output logic             o_rd_avail,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_dout,
  input  logic             i_rd_done,
  output logic [7:0]       o_drop_cnt
);

  typedef enum logic {
    FREE = 1'b0,
    FULL = 1'b1
  } bank_state_t;

  bank_state_t      bank_q [2];
  bank_state_t      bank_d [2];
  logic             wsel_q, wsel_d;
  logic             rsel_q, rsel_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wr_fire, rd_fire;

  logic [WIDTH-1:0] mem [2][DEPTH];

  assign o_wr_ready = (bank_q[wsel_q] == FREE);
  assign o_rd_avail = (bank_q[rsel_q] == FULL);
  assign o_wr_fill  = waddr_q;
  assign o_dout     = dout_q;
  assign wr_fire    = i_wr_valid && o_wr_ready;
  assign rd_fire    = i_rd_done && o_rd_avail;

  // The write bank is FREE and the read bank FULL whenever both fire,
  // so the two updates always target different banks.
  always_comb begin
    bank_d  = bank_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    waddr_d = waddr_q;
    if (wr_fire) begin
      if (waddr_q == AW'(DEPTH - 1)) begin
        waddr_d         = '0;
        bank_d[wsel_q]  = FULL;
        wsel_d          = ~wsel_q;
      end else begin
        waddr_d = waddr_q + 1'b1;
      end
    end
    if (rd_fire) begin
      bank_d[rsel_q] = FREE;
      rsel_d         = ~rsel_q;
    end
  end

  always_comb begin
    dout_d = '0;
    if (i_raddr < AW'(DEPTH)) begin
      dout_d = mem[rsel_q][i_raddr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bank_q[0] <= FREE;
      bank_q[1] <= FREE;
      wsel_q    <= 1'b0;
      rsel_q    <= 1'b0;
      waddr_q   <= '0;
      dout_q    <= '0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wsel_q    <= wsel_d;
      rsel_q    <= rsel_d;
      waddr_q   <= waddr_d;
      dout_q    <= dout_d;
    end
  end

  // Sample storage is never cleared; a reset only forgets where the data is.
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_fire) begin
      mem[wsel_q][waddr_q] <= i_wr_data;
    end
  end

`ifdef WINDOW_PINGPONG_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (i_wr_valid && !o_wr_ready && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drop_q <= 8'd0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign o_drop_cnt = drop_q;
`else
  assign o_drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_window_pingpong_bram.sv
// tb/tb_window_pingpong_bram.sv - directed plus random checks of window_pingpong_bram against a window-queue model
module tb_window_pingpong_bram;

  localparam int WIDTH = 8;
  localparam int FILTER = 1;
  localparam int DEPTH = 9;
  localparam int AW = 4;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic             i_wr_valid = 1'b0;
  logic [WIDTH-1:0] i_wr_data = '0;
  logic             o_wr_ready;
  logic [AW-1:0]    o_wr_fill;
  logic             o_rd_avail;
  logic [AW-1:0]    i_raddr = '0;
  logic [WIDTH-1:0] o_dout;
  logic             i_rd_done = 1'b0;
  logic [7:0]       o_drop_cnt;

  window_pingpong_bram #(.WIDTH(WIDTH), .FILTER(FILTER)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_valid (i_wr_valid),
    .i_wr_data  (i_wr_data),
    .o_wr_ready (o_wr_ready),
    .o_wr_fill  (o_wr_fill),
    .o_rd_avail (o_rd_avail),
    .i_raddr    (i_raddr),
    .o_dout     (o_dout),
    .i_rd_done  (i_rd_done),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Model: completed windows waiting for the reader, in fill order, plus the partial one.
  typedef logic [DEPTH-1:0][WIDTH-1:0] win_t;
  win_t       wins[$];
  logic [7:0] part[$];
  int         m_drop;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("wr_ready", 32'(o_wr_ready), 32'(wins.size() < 2));
    check("rd_avail", 32'(o_rd_avail), 32'(wins.size() > 0));
    check("wr_fill", 32'(o_wr_fill), 32'(part.size()));
    check("drop_cnt", 32'(o_drop_cnt), 32'(m_drop));
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic [3:0] ra,
                       input logic done, input logic rst);
    logic       ready, avail, dout_known;
    logic [7:0] exp_dout;
    win_t       w;
    i_wr_valid = v;
    i_wr_data  = d;
    i_raddr    = ra;
    i_rd_done  = done;
    i_rst      = rst;
    check_state();
    ready = (wins.size() < 2);
    avail = (wins.size() > 0);
    dout_known = 1'b1;
    exp_dout = 8'd0;
    if (!rst && ra < DEPTH) begin
      if (avail) exp_dout = wins[0][ra];
      else dout_known = 1'b0;
    end
    @(posedge i_clk);
    #1;
    if (rst) begin
      wins.delete();
      part.delete();
      m_drop = 0;
    end else begin
`ifdef WINDOW_PINGPONG_DROP_CNT_EN
      if (v && !ready && m_drop < 255) m_drop++;
`endif
      if (done && avail) void'(wins.pop_front());
      if (v && ready) begin
        part.push_back(d);
        if (part.size() == DEPTH) begin
          for (int i = 0; i < DEPTH; i++) w[i] = part[i];
          wins.push_back(w);
          part.delete();
        end
      end
    end
    if (dout_known) check("dout", 32'(o_dout), 32'(exp_dout));
    i_rst = 1'b0;
    i_wr_valid = 1'b0;
    i_rd_done = 1'b0;
  endtask

  initial begin
    m_drop = 0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("reset_dout", 32'(o_dout), 32'd0);
    check_state();

    // First window 1..9, then read centre sample.
    for (int i = 1; i <= 9; i++) cycle(1'b1, 8'(i), 4'd0, 1'b0, 1'b0);
    check("avail_after_fill", 32'(o_rd_avail), 32'd1);
    cycle(1'b0, 8'd0, 4'd4, 1'b0, 1'b0);
    check("centre_sample", 32'(o_dout), 32'd5);

    // Second window 10..18, then an offered write that must be dropped.
    for (int i = 10; i <= 18; i++) cycle(1'b1, 8'(i), 4'd0, 1'b0, 1'b0);
    check("both_full_ready", 32'(o_wr_ready), 32'd0);
    cycle(1'b1, 8'd19, 4'd8, 1'b0, 1'b0);
    check("dropped_fill", 32'(o_wr_fill), 32'd0);

    // Release bank 0; reader moves to the window starting at 10.
    cycle(1'b0, 8'd0, 4'd0, 1'b1, 1'b0);
    check("ready_after_release", 32'(o_wr_ready), 32'd1);
    cycle(1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
    check("second_window_first", 32'(o_dout), 32'd10);

    // Release bank 1 and refill so the last write lands with a release.
    cycle(1'b0, 8'd0, 4'd0, 1'b1, 1'b0);
    for (int i = 20; i < 28; i++) cycle(1'b1, 8'(i), 4'd0, 1'b0, 1'b0);
    for (int i = 30; i < 39; i++) cycle(1'b1, 8'(i), 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 8'd28, 4'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 4'd2, 1'b0, 1'b0);

    // Reset mid-fill with a write pending.
    cycle(1'b0, 8'd0, 4'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(40 + i), 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 8'd45, 4'd3, 1'b0, 1'b1);
    check("rst_fill", 32'(o_wr_fill), 32'd0);
    check("rst_dout", 32'(o_dout), 32'd0);

    // Release with nothing available and an out-of-range address.
    cycle(1'b0, 8'd0, 4'd12, 1'b1, 1'b0);
    check("oob_dout", 32'(o_dout), 32'd0);

    for (int n = 0; n < 600; n++) begin
      cycle(($urandom % 4) != 0, 8'($urandom), 4'($urandom % 12),
            ($urandom % 10) == 0, ($urandom % 150) == 0);
    end
    check_state();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/window_pingpong_bram.md
WINDOW_PINGPONG_BRAM -- requirements
Module: window_pingpong_bram

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per window sample.
REQ-002 SHALL have parameter FILTER, default 3, filter radius; DEPTH = (2*FILTER+1)^2 (49 at default), derived internally, not overridable; AW = clog2(DEPTH).
REQ-003 SHALL have port i_clk, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port i_wr_valid, input, 1, write sample offered.
REQ-006 SHALL have port i_wr_data, input, WIDTH, write sample.
REQ-007 SHALL have port o_wr_ready, output, 1, write bank can accept.
REQ-008 SHALL have port o_wr_fill, output, AW, samples written into the current write bank.
REQ-009 SHALL have port o_rd_avail, output, 1, a full window is held in the read bank.
REQ-010 SHALL have port i_raddr, input, AW, read address within the read bank.
REQ-011 SHALL have port o_dout, output, WIDTH, registered read data.
REQ-012 SHALL have port i_rd_done, input, 1, single-cycle pulse that releases the read bank.
REQ-013 SHALL have port o_drop_cnt, output, 8, count of rejected writes (see Configuration).

Function
REQ-014 SHALL hold two banks of DEPTH x WIDTH; each bank is in state FREE or FULL; wsel and rsel are 1-bit bank pointers.
REQ-015 o_wr_ready SHALL equal (bank[wsel]==FREE), combinational from state only.
REQ-016 Write accepted when i_wr_valid && o_wr_ready: mem[wsel][waddr] <= i_wr_data, waddr increments.
REQ-017 On accepted write with waddr==DEPTH-1: waddr <= 0, bank[wsel] <= FULL, wsel toggles (wrap-around).
REQ-018 o_wr_fill SHALL equal waddr.
REQ-019 o_rd_avail SHALL equal (bank[rsel]==FULL).
REQ-020 o_dout SHALL update every cycle to mem[rsel][i_raddr], 1-cycle latency; i_raddr >= DEPTH SHALL yield 0.
REQ-021 i_rd_done while o_rd_avail: bank[rsel] <= FREE, rsel toggles; i_rd_done while !o_rd_avail SHALL be ignored.
REQ-022 Final write into one bank and i_rd_done on the other bank in the same cycle SHALL both take effect.
REQ-023 When both banks are FULL, o_wr_ready = 0; writes offered are dropped, contents and waddr unchanged.
REQ-024 A completed bank SHALL be readable (o_rd_avail=1) the cycle after its final write if it is at rsel.
REQ-025 Banks SHALL be handed to the reader strictly in fill order (bank 0 first after reset).

Reset
REQ-026 On i_rst: both banks FREE, wsel=0, rsel=0, waddr=0, o_dout=0, o_drop_cnt=0; hence o_wr_ready=1, o_rd_avail=0, o_wr_fill=0.
REQ-027 Memory contents SHALL NOT be cleared by reset; reset mid-fill discards the partial window.
REQ-028 i_rst SHALL take priority over every write, read and release in the same cycle.

Configuration
REQ-029 Macro WINDOW_PINGPONG_DROP_CNT_EN: when defined, o_drop_cnt increments on each cycle with i_wr_valid && !o_wr_ready, saturating at 255.
REQ-030 Without WINDOW_PINGPONG_DROP_CNT_EN, o_drop_cnt SHALL be constant 0 and no counter logic is built; all other behaviour identical.

Verification (FILTER=1, DEPTH=9, WIDTH=8)
REQ-031 Reset, then write 1..9 back-to-back -> o_wr_fill 0..8 then 0, o_rd_avail=1 next cycle, i_raddr=4 gives o_dout=5 one cycle later.
REQ-032 Write 18 samples with no release -> after 18th, o_wr_ready=0; 19th valid dropped, o_drop_cnt=1 (macro defined) / 0 (undefined).
REQ-033 Both banks full, pulse i_rd_done -> o_wr_ready=1 next cycle, o_rd_avail stays 1, i_raddr=0 now returns sample 10.
REQ-034 Final write of bank 1 coincident with i_rd_done of bank 0 -> bank 0 FREE, bank 1 FULL, rsel=1, o_rd_avail=1, o_wr_ready=1.
REQ-035 i_rst asserted after 5 writes and with i_wr_valid high -> o_wr_fill=0, o_rd_avail=0, o_dout=0, that write not counted.
REQ-036 i_rd_done with o_rd_avail=0 and i_raddr=12 -> no state change, o_dout=0.
